// File: rtl/instr_fetch.sv
// instr_fetch: fetch stage between the PC and the async instruction ROM.
// Owns the PC, drives the ROM address combinationally from it, and
// registers the returned word into an instruction register (IR) that is
// handed to decode with a valid/ready handshake. Execute can redirect the
// PC at any time, which flushes the IR.
//
// Optional build macro: IFETCH_BRANCH_DECODE_EN
//   When defined, an unconditional branch (opcode 4'b0101) is recognised
//   as it is captured. The PC then jumps straight to the target held in the
//   low ADDR_WIDTH bits of the word, and the IR is tagged with
//   ir_pred_taken. When undefined, such words are fetched sequentially and
//   ir_pred_taken is tied low.
module instr_fetch #(
  parameter int DATA_WIDTH = 38,
  parameter int ADDR_WIDTH = 12,
  parameter int RESET_PC   = 0,
  parameter int PROG_LEN   = 169
) (
  input  logic                  clk,
  input  logic                  rst,
  output logic [ADDR_WIDTH-1:0] rom_addr,
  input  logic [DATA_WIDTH-1:0] rom_data,
  output logic                  ir_valid,
  input  logic                  ir_ready,
  output logic [DATA_WIDTH-1:0] ir_instr,
  output logic [ADDR_WIDTH-1:0] ir_pc,
  output logic [3:0]            ir_opcode,
  output logic [1:0]            ir_mode,
  output logic [15:0]           ir_a,
  output logic [15:0]           ir_b,
  output logic                  ir_pred_taken,
  input  logic                  redirect_valid,
  input  logic [ADDR_WIDTH-1:0] redirect_pc,
  output logic                  fetch_done
);

  // One extra bit so that PROG_LEN = 2^ADDR_WIDTH is representable; in that
  // case every PC is in range and the wrap from all-ones to 0 never ends
  // the program.
  localparam logic [ADDR_WIDTH-1:0] LP_RESET_PC = ADDR_WIDTH'(RESET_PC);
  localparam logic [ADDR_WIDTH:0]   LP_PROG_LEN = (ADDR_WIDTH+1)'(PROG_LEN);

  typedef enum logic {
    ST_FETCH = 1'b0,
    ST_DONE  = 1'b1
  } state_t;

  state_t                r_state;
  logic [ADDR_WIDTH-1:0] r_pc;
  logic [ADDR_WIDTH-1:0] r_ir_pc;
  logic [DATA_WIDTH-1:0] r_ir_instr;
  logic                  r_ir_valid;
  logic                  r_fetch_done;

  logic                  w_slot_free;
  logic                  w_pc_in_range;
  logic                  w_capture;
  logic                  w_is_branch;
  logic [ADDR_WIDTH-1:0] w_pc_inc;
  logic [ADDR_WIDTH-1:0] w_next_pc;
  logic                  w_next_in_range;
  logic                  w_redirect_in_range;

  // The IR can take a new word if it is empty or is being drained now.
  assign w_slot_free   = !r_ir_valid || ir_ready;
  assign w_pc_in_range = {1'b0, r_pc} < LP_PROG_LEN;
  assign w_capture     = (r_state == ST_FETCH) && w_pc_in_range && w_slot_free;

  // Sequential successor wraps naturally at the PC width.
  assign w_pc_inc = r_pc + 1'b1;

`ifdef IFETCH_BRANCH_DECODE_EN
  assign w_is_branch = (rom_data[DATA_WIDTH-1 -: 4] == 4'b0101);
`else
  assign w_is_branch = 1'b0;
`endif

  assign w_next_pc           = w_is_branch ? rom_data[ADDR_WIDTH-1:0] : w_pc_inc;
  assign w_next_in_range     = {1'b0, w_next_pc} < LP_PROG_LEN;
  assign w_redirect_in_range = {1'b0, redirect_pc} < LP_PROG_LEN;

  // Fetch FSM: PC, IR capture, IR drain and the registered done flag.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state      <= ST_FETCH;
      r_pc         <= LP_RESET_PC;
      r_ir_valid   <= 1'b0;
      r_ir_instr   <= '0;
      r_ir_pc      <= '0;
      r_fetch_done <= 1'b0;
    end else if (redirect_valid) begin
      // Flush wins even over a same-cycle handshake; nothing is captured.
      r_pc       <= redirect_pc;
      r_ir_valid <= 1'b0;
      if (w_redirect_in_range) begin
        r_state      <= ST_FETCH;
        r_fetch_done <= 1'b0;
      end else begin
        r_state      <= ST_DONE;
        r_fetch_done <= 1'b1;
      end
    end else begin
      case (r_state)
        ST_FETCH: begin
          if (!w_pc_in_range) begin
            // Entered FETCH with a PC already past the end (e.g. a reset
            // PC outside the program): stop without fetching.
            r_state      <= ST_DONE;
            r_fetch_done <= 1'b1;
            if (ir_ready) begin
              r_ir_valid <= 1'b0;
            end
          end else if (w_slot_free) begin
            r_ir_instr <= rom_data;
            r_ir_pc    <= r_pc;
            r_ir_valid <= 1'b1;
            r_pc       <= w_next_pc;
            if (!w_next_in_range) begin
              r_state      <= ST_DONE;
              r_fetch_done <= 1'b1;
            end
          end
        end
        ST_DONE: begin
          // Keep presenting the last word until decode takes it.
          if (ir_ready) begin
            r_ir_valid <= 1'b0;
          end
        end
        default: begin
          r_state <= ST_FETCH;
        end
      endcase
    end
  end

`ifdef IFETCH_BRANCH_DECODE_EN
  logic r_ir_pred_taken;

  // Tag each captured word with whether it steered the PC to its target.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_ir_pred_taken <= 1'b0;
    end else if (redirect_valid) begin
      r_ir_pred_taken <= 1'b0;
    end else if (w_capture) begin
      r_ir_pred_taken <= w_is_branch;
    end
  end

  assign ir_pred_taken = r_ir_pred_taken;
`else
  assign ir_pred_taken = 1'b0;
`endif

  assign rom_addr   = r_pc;
  assign ir_valid   = r_ir_valid;
  assign ir_instr   = r_ir_instr;
  assign ir_pc      = r_ir_pc;
  assign fetch_done = r_fetch_done;

  // Decode-facing fields are plain slices of the IR.
  assign ir_opcode = r_ir_instr[DATA_WIDTH-1 -: 4];
  assign ir_mode   = r_ir_instr[DATA_WIDTH-5 -: 2];
  assign ir_a      = r_ir_instr[31:16];
  assign ir_b      = r_ir_instr[15:0];

endmodule

// File: tb/tb_instr_fetch.sv
// tb_instr_fetch: directed scenarios plus randomized ready/redirect/reset
// traffic. A program-order reference model produces the expected stream of
// accepted words into a queue; a separate monitor pops on every handshake.
module tb_instr_fetch;

  localparam int DW       = 38;
  localparam int AW       = 12;
  localparam int PROG_LEN = 169;

  logic          clk;
  logic          rst;
  logic [AW-1:0] rom_addr;
  logic [DW-1:0] rom_data;
  logic          ir_valid;
  logic          ir_ready;
  logic [DW-1:0] ir_instr;
  logic [AW-1:0] ir_pc;
  logic [3:0]    ir_opcode;
  logic [1:0]    ir_mode;
  logic [15:0]   ir_a;
  logic [15:0]   ir_b;
  logic          ir_pred_taken;
  logic          redirect_valid;
  logic [AW-1:0] redirect_pc;
  logic          fetch_done;

  logic [DW-1:0] rom [0:(1<<AW)-1];

  typedef struct {
    logic [AW-1:0] pc;
    logic [DW-1:0] instr;
    logic          taken;
  } exp_t;

  exp_t exp_q[$];

  int checks   = 0;
  int failures = 0;

  instr_fetch #(
    .DATA_WIDTH(DW),
    .ADDR_WIDTH(AW),
    .RESET_PC  (0),
    .PROG_LEN  (PROG_LEN)
  ) dut (
    .clk           (clk),
    .rst           (rst),
    .rom_addr      (rom_addr),
    .rom_data      (rom_data),
    .ir_valid      (ir_valid),
    .ir_ready      (ir_ready),
    .ir_instr      (ir_instr),
    .ir_pc         (ir_pc),
    .ir_opcode     (ir_opcode),
    .ir_mode       (ir_mode),
    .ir_a          (ir_a),
    .ir_b          (ir_b),
    .ir_pred_taken (ir_pred_taken),
    .redirect_valid(redirect_valid),
    .redirect_pc   (redirect_pc),
    .fetch_done    (fetch_done)
  );

  // Asynchronous ROM model.
  assign rom_data = rom[rom_addr];

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Reference model: the words decode must see, in program order, starting
  // at 'start' and ending when the address leaves the program.
  task automatic push_path(input int start);
    int   pc;
    int   nxt;
    int   guard;
    exp_t e;
    exp_q.delete();
    pc    = start;
    guard = 0;
    while (pc < PROG_LEN && guard < 4 * PROG_LEN) begin
      e.pc    = AW'(pc);
      e.instr = rom[pc];
      e.taken = 1'b0;
      nxt     = (pc + 1) % (1 << AW);
`ifdef IFETCH_BRANCH_DECODE_EN
      if (e.instr[37:34] == 4'b0101) begin
        nxt     = int'(e.instr[AW-1:0]);
        e.taken = 1'b1;
      end
`endif
      exp_q.push_back(e);
      pc = nxt;
      guard++;
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Monitor: scoreboard pop on each accepted word, plus stall-hold check.
  initial begin : monitor
    logic          hold_pending;
    logic [AW-1:0] hold_pc;
    logic [DW-1:0] hold_instr;
    exp_t          e;
    hold_pending = 1'b0;
    hold_pc      = '0;
    hold_instr   = '0;
    forever begin
      @(negedge clk);
      if (hold_pending) begin
        check("stall_hold_valid", 64'(ir_valid), 64'd1);
        check("stall_hold_pc", 64'(ir_pc), 64'(hold_pc));
        check("stall_hold_instr", 64'(ir_instr), 64'(hold_instr));
      end
      hold_pending = 1'b0;
      if (!rst && !redirect_valid && ir_valid) begin
        if (ir_ready) begin
          if (exp_q.size() == 0) begin
            check("sb_unexpected_word", 64'(ir_pc), 64'hFFFF_FFFF);
          end else begin
            e = exp_q.pop_front();
            $display("TXN pc=%0d instr=%h pred=%0d", ir_pc, ir_instr, ir_pred_taken);
            check("sb_pc", 64'(ir_pc), 64'(e.pc));
            check("sb_instr", 64'(ir_instr), 64'(e.instr));
            check("sb_pred", 64'(ir_pred_taken), 64'(e.taken));
            check("sb_opcode", 64'(ir_opcode), 64'(e.instr[37:34]));
            check("sb_mode", 64'(ir_mode), 64'(e.instr[33:32]));
            check("sb_a", 64'(ir_a), 64'(e.instr[31:16]));
            check("sb_b", 64'(ir_b), 64'(e.instr[15:0]));
          end
        end else begin
          hold_pending = 1'b1;
          hold_pc      = ir_pc;
          hold_instr   = ir_instr;
        end
      end
    end
  end

  initial begin : stimulus
    logic [63:0] rnd;
    logic        drained;
    int          r;
    int          exp_after_branch;

    // Random program without branches, then the fixed test words.
    for (int i = 0; i < (1 << AW); i++) begin
      rnd = {$urandom, $urandom};
      if (rnd[37:34] == 4'b0101) rnd[37:34] = 4'b0110;
      rom[i] = rnd[DW-1:0];
    end
    rom[0]   = 38'h0;
    rom[1]   = 38'h4_0000_0001;
    rom[2]   = 38'h4_1000_0002;
    rom[110] = 38'h4_0000_000F;
    rom[115] = 38'h14_0000_0075;

    rst            = 1'b1;
    ir_ready       = 1'b1;
    redirect_valid = 1'b0;
    redirect_pc    = '0;

    // Reset state.
    repeat (3) tick();
    check("rst_valid", 64'(ir_valid), 64'd0);
    check("rst_instr", 64'(ir_instr), 64'd0);
    check("rst_ir_pc", 64'(ir_pc), 64'd0);
    check("rst_pred", 64'(ir_pred_taken), 64'd0);
    check("rst_done", 64'(fetch_done), 64'd0);
    check("rst_rom_addr", 64'(rom_addr), 64'd0);

    // 1: first fetches after reset release.
    rst = 1'b0;
    push_path(0);
    check("t1_first_rom_addr", 64'(rom_addr), 64'd0);
    check("t1_first_valid", 64'(ir_valid), 64'd0);
    tick();
    check("t1_w0_valid", 64'(ir_valid), 64'd1);
    check("t1_w0_pc", 64'(ir_pc), 64'd0);
    check("t1_w0_instr", 64'(ir_instr), 64'd0);
    tick();
    check("t1_w1_pc", 64'(ir_pc), 64'd1);
    check("t1_w1_instr", 64'(ir_instr), 64'h4_0000_0001);
    check("t1_w1_opcode", 64'(ir_opcode), 64'd1);
    check("t1_w1_b", 64'(ir_b), 64'd1);
    tick();
    check("t2_w2_pc", 64'(ir_pc), 64'd2);

    // 2: stall for three cycles while the IR holds address 2.
    ir_ready = 1'b0;
    for (int k = 0; k < 3; k++) begin
      tick();
      check("t2_stall_instr", 64'(ir_instr), 64'h4_1000_0002);
      check("t2_stall_rom_addr", 64'(rom_addr), 64'd3);
    end
    ir_ready = 1'b1;
    tick();
    check("t2_release_pc3", 64'(ir_pc), 64'd3);
    tick();
    check("t2_release_pc4", 64'(ir_pc), 64'd4);

    // 3: redirect during a stall.
    ir_ready       = 1'b0;
    redirect_valid = 1'b1;
    redirect_pc    = 12'd110;
    push_path(110);
    tick();
    check("t3_flush_valid", 64'(ir_valid), 64'd0);
    check("t3_rom_addr", 64'(rom_addr), 64'd110);
    redirect_valid = 1'b0;
    ir_ready       = 1'b1;
    tick();
    check("t3_target_valid", 64'(ir_valid), 64'd1);
    check("t3_target_pc", 64'(ir_pc), 64'd110);
    check("t3_target_instr", 64'(ir_instr), 64'h4_0000_000F);

    // 4: run to the end of the program at full throughput.
    redirect_valid = 1'b1;
    redirect_pc    = 12'd160;
    push_path(160);
    tick();
    check("t4_flush_valid", 64'(ir_valid), 64'd0);
    check("t4_rom_addr", 64'(rom_addr), 64'd160);
    redirect_valid = 1'b0;
    tick();
    check("t4_pc160", 64'(ir_pc), 64'd160);
    for (int k = 161; k <= 168; k++) begin
      tick();
      check("t4_seq_valid", 64'(ir_valid), 64'd1);
      check("t4_seq_pc", 64'(ir_pc), 64'(k));
    end
    tick();
    check("t4_end_valid", 64'(ir_valid), 64'd0);
    check("t4_end_done", 64'(fetch_done), 64'd1);
    check("t4_end_rom_addr", 64'(rom_addr), 64'd169);
    tick();
    check("t4_idle_valid", 64'(ir_valid), 64'd0);
    check("t4_idle_rom_addr", 64'(rom_addr), 64'd169);
    check("t4_queue_empty", 64'(exp_q.size()), 64'd0);

    // 5: unconditional branch word at 115.
    redirect_valid = 1'b1;
    redirect_pc    = 12'd115;
    push_path(115);
    tick();
    check("t5_flush_valid", 64'(ir_valid), 64'd0);
    redirect_valid = 1'b0;
    tick();
    check("t5_pc115", 64'(ir_pc), 64'd115);
    check("t5_done_cleared", 64'(fetch_done), 64'd0);
`ifdef IFETCH_BRANCH_DECODE_EN
    check("t5_pred_on_branch", 64'(ir_pred_taken), 64'd1);
    exp_after_branch = 117;
`else
    check("t5_pred_on_branch", 64'(ir_pred_taken), 64'd0);
    exp_after_branch = 116;
`endif
    tick();
    check("t5_next_pc", 64'(ir_pc), 64'(exp_after_branch));
    check("t5_next_pred", 64'(ir_pred_taken), 64'd0);

    // 6: reset during a stall beats a simultaneous redirect.
    redirect_valid = 1'b1;
    redirect_pc    = 12'd50;
    push_path(50);
    tick();
    redirect_valid = 1'b0;
    tick();
    check("t6_pc50", 64'(ir_pc), 64'd50);
    ir_ready = 1'b0;
    tick();
    check("t6_stall_valid", 64'(ir_valid), 64'd1);
    rst            = 1'b1;
    redirect_valid = 1'b1;
    redirect_pc    = 12'd120;
    push_path(0);
    tick();
    check("t6_rst_valid", 64'(ir_valid), 64'd0);
    check("t6_rst_rom_addr", 64'(rom_addr), 64'd0);
    check("t6_rst_done", 64'(fetch_done), 64'd0);
    rst            = 1'b0;
    redirect_valid = 1'b0;
    ir_ready       = 1'b1;
    tick();
    check("t6_after_rst_pc", 64'(ir_pc), 64'd0);
    check("t6_after_rst_valid", 64'(ir_valid), 64'd1);

    // Randomized traffic: ready bubbles, redirects (some past the end), resets.
    for (int c = 0; c < 3000; c++) begin
      rst            = 1'b0;
      redirect_valid = 1'b0;
      ir_ready       = ($urandom_range(0, 3) != 0);
      r              = int'($urandom_range(0, 299));
      if (r == 0) begin
        rst            = 1'b1;
        redirect_valid = 1'($urandom_range(0, 1));
        redirect_pc    = AW'($urandom_range(0, 200));
        push_path(0);
      end else if (r < 8) begin
        redirect_valid = 1'b1;
        redirect_pc    = AW'($urandom_range(0, 200));
        push_path(int'(redirect_pc));
      end
      tick();
    end

    // Drain: every expected word must arrive, then fetch must report done.
    rst            = 1'b0;
    redirect_valid = 1'b0;
    ir_ready       = 1'b1;
    drained        = 1'b0;
    for (int c = 0; c < 400 && !drained; c++) begin
      tick();
      if (exp_q.size() == 0 && !ir_valid) drained = 1'b1;
    end
    check("drain_complete", 64'(drained), 64'd1);
    check("drain_done_flag", 64'(fetch_done), 64'd1);
    check("drain_rom_addr_past_end", 64'(rom_addr >= AW'(PROG_LEN)), 64'd1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
